// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the key debouncer family.
`timescale 1ns/1ps
package debounce_pkg;

  // Debounce window in clock cycles; never less than one cycle.
  function automatic int unsigned calc_deb_cycles(input int unsigned clk_mhz,
                                                  input int unsigned glitch_ns);
    int unsigned cycles;
    cycles = (glitch_ns * clk_mhz) / 1000;
    return (cycles < 1) ? 1 : cycles;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key: synchroniser, stable-state register, debounce counter and press/release strobes.
`timescale 1ns/1ps
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 1,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic key_i,
  output logic state_o,
  output logic press_stb_o,
  output logic release_stb_o
);

  localparam int unsigned          CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]          CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{ACTIVE_LOW}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw_pressed;
  logic                   state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  // Sync chain resets to the released level so reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= SYNC_RST;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
    end
  end

  assign raw_pressed = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Any match clears the counter; acceptance needs DEB_CYCLES consecutive mismatches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (raw_pressed != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d   = raw_pressed;
        press_d   = raw_pressed;
        release_d = ~raw_pressed;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state_o       = state_q;
  assign press_stb_o   = press_q;
  assign release_stb_o = release_q;

endmodule

// File: rtl/multi_key_debouncer.sv
// NUM_KEYS independent debounce channels plus a combined any-pressed flag.
`timescale 1ns/1ps
module multi_key_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned CLK_FREQ_MHZ   = 20,
  parameter int unsigned GLITCH_TIME_NS = 50,
  parameter int unsigned ACTIVE_LOW     = 1,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic [NUM_KEYS-1:0] key_i,
  output logic [NUM_KEYS-1:0] key_state_o,
  output logic [NUM_KEYS-1:0] key_pressed_stb_o,
  output logic [NUM_KEYS-1:0] key_released_stb_o,
  output logic                any_pressed_o
);

  localparam int unsigned DEB_CYCLES = calc_deb_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    debounce_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW != 0),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk_i        (clk_i),
      .srst_i       (srst_i),
      .key_i        (key_i[k]),
      .state_o      (key_state_o[k]),
      .press_stb_o  (key_pressed_stb_o[k]),
      .release_stb_o(key_released_stb_o[k])
    );
  end

  assign any_pressed_o = |key_state_o;

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed bench: DEB_CYCLES=10, two sync stages, active-low keys.
`timescale 1ns/1ps
module tb_multi_key_debouncer;

  logic       clk_i = 1'b0;
  logic       srst_i;
  logic [3:0] key_i;
  logic [3:0] key_state_o;
  logic [3:0] key_pressed_stb_o;
  logic [3:0] key_released_stb_o;
  logic       any_pressed_o;

  int checks   = 0;
  int failures = 0;

  multi_key_debouncer #(
    .NUM_KEYS      (4),
    .CLK_FREQ_MHZ  (20),
    .GLITCH_TIME_NS(500),
    .ACTIVE_LOW    (1),
    .SYNC_STAGES   (2)
  ) dut (
    .clk_i             (clk_i),
    .srst_i            (srst_i),
    .key_i             (key_i),
    .key_state_o       (key_state_o),
    .key_pressed_stb_o (key_pressed_stb_o),
    .key_released_stb_o(key_released_stb_o),
    .any_pressed_o     (any_pressed_o)
  );

  always #25 clk_i = ~clk_i;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Expect no strobes for the first 11 edges after a change, then the given press/release strobes.
  task automatic expect_after_latency(input string name, input logic [3:0] exp_press,
                                      input logic [3:0] exp_rel, input logic [3:0] exp_state);
    logic early;
    early = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      if ((key_pressed_stb_o | key_released_stb_o) != 4'b0000) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL %s_early: strobe seen before latency, got 1 expected 0", name);
    end
    step();
    checks++;
    if (key_pressed_stb_o !== exp_press) begin
      failures++;
      $display("FAIL %s_press: got %b expected %b", name, key_pressed_stb_o, exp_press);
    end
    checks++;
    if (key_released_stb_o !== exp_rel) begin
      failures++;
      $display("FAIL %s_release: got %b expected %b", name, key_released_stb_o, exp_rel);
    end
    checks++;
    if (key_state_o !== exp_state) begin
      failures++;
      $display("FAIL %s_state: got %b expected %b", name, key_state_o, exp_state);
    end
    checks++;
    if (any_pressed_o !== (exp_state != 4'b0000)) begin
      failures++;
      $display("FAIL %s_any: got %b expected %b", name, any_pressed_o, exp_state != 4'b0000);
    end
    step();
    checks++;
    if ((key_pressed_stb_o | key_released_stb_o) !== 4'b0000) begin
      failures++;
      $display("FAIL %s_one_cycle: got %b expected 0000", name,
               key_pressed_stb_o | key_released_stb_o);
    end
    checks++;
    if (key_state_o !== exp_state) begin
      failures++;
      $display("FAIL %s_state_hold: got %b expected %b", name, key_state_o, exp_state);
    end
  endtask

  task automatic test_reset();
    srst_i = 1'b1;
    key_i  = 4'b1111;
    repeat (3) step();
    checks++;
    if ({key_state_o, key_pressed_stb_o, key_released_stb_o, any_pressed_o} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b/%b/%b/%b expected all 0", key_state_o,
               key_pressed_stb_o, key_released_stb_o, any_pressed_o);
    end
    srst_i = 1'b0;
    repeat (15) step();
    checks++;
    if (key_state_o !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle_state: got %b expected 0000", key_state_o);
    end
  endtask

  task automatic test_glitch();
    logic bad;
    bad = 1'b0;
    for (int r = 0; r < 5; r++) begin
      key_i[1] = 1'b0;
      for (int i = 0; i < 9; i++) begin
        step();
        if ((key_pressed_stb_o | key_released_stb_o | key_state_o) != 4'b0000) bad = 1'b1;
      end
      key_i[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        if ((key_pressed_stb_o | key_released_stb_o | key_state_o) != 4'b0000) bad = 1'b1;
      end
    end
    repeat (4) begin
      step();
      if ((key_pressed_stb_o | key_released_stb_o | key_state_o) != 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL glitch_reject: activity seen, got 1 expected 0");
    end
  endtask

  task automatic test_clean_press();
    key_i[0] = 1'b0;
    expect_after_latency("clean_press", 4'b0001, 4'b0000, 4'b0001);
  endtask

  task automatic test_release();
    key_i[0] = 1'b1;
    expect_after_latency("release", 4'b0000, 4'b0001, 4'b0000);
  endtask

  task automatic test_bounce();
    logic bad;
    bad = 1'b0;
    for (int seg = 0; seg < 10; seg++) begin
      key_i[2] = seg[0];
      for (int i = 0; i < 3; i++) begin
        step();
        if ((key_pressed_stb_o | key_released_stb_o) != 4'b0000) bad = 1'b1;
      end
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL bounce_no_early: strobe during bounce, got 1 expected 0");
    end
    key_i[2] = 1'b0;
    expect_after_latency("bounce_settle", 4'b0100, 4'b0000, 4'b0100);
    key_i[2] = 1'b1;
    expect_after_latency("bounce_release", 4'b0000, 4'b0100, 4'b0000);
  endtask

  task automatic test_simultaneous();
    key_i = 4'b0101;
    expect_after_latency("simul_press", 4'b1010, 4'b0000, 4'b1010);
    key_i = 4'b1111;
    expect_after_latency("simul_release", 4'b0000, 4'b1010, 4'b0000);
  endtask

  task automatic test_reset_mid_debounce();
    logic early;
    early = 1'b0;
    key_i[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if ((key_pressed_stb_o | key_state_o) != 4'b0000) early = 1'b1;
    end
    srst_i = 1'b1;
    step();
    checks++;
    if ({key_state_o, key_pressed_stb_o, key_released_stb_o, any_pressed_o} !== 13'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got %b/%b/%b/%b expected all 0", key_state_o,
               key_pressed_stb_o, key_released_stb_o, any_pressed_o);
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL midreset_before: activity before reset, got 1 expected 0");
    end
    srst_i = 1'b0;
    expect_after_latency("midreset_press", 4'b1000, 4'b0000, 4'b1000);
  endtask

  initial begin
    srst_i = 1'b1;
    key_i  = 4'b1111;
    test_reset();
    test_glitch();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
